weight_loader: RTL and testbench

//  Responder to the accelerator main FSM's weight_start/weight_done handshake.
//  On each start pulse it fetches the fused 3x3 kernels of one output channel
//  (in_ch words) from weight SRAM and writes them into a ping-pong weight buffer.
//  It then returns a one-cycle weight_done pulse, so conv can consume one bank

---
 rtl/acc_pkg.sv | 21 ++
 rtl/wl_addr_gen.sv | 42 ++++
 rtl/weight_loader.sv | 142 ++++++++++++++
 tb/tb_weight_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared accelerator definitions: weight/kernel widths, weight loader
// state encodings and the channel-offset multiply helper.
package acc_pkg;

   localparam int unsigned WW = 8;        // bits per weight
   localparam int unsigned KW = 9 * WW;   // one fused 3x3 kernel per word

   typedef enum logic [2:0] {
      WL_IDLE  = 3'd0,
      WL_CALC  = 3'd1,
      WL_READ  = 3'd2,
      WL_DRAIN = 3'd3,
      WL_DONE  = 3'd4
   } wl_state_t;

   // Full-precision product of two 8-bit channel quantities.
   function automatic logic [15:0] mul8x8(input logic [7:0] a, input logic [7:0] b);
      return 16'(a) * 16'(b);
   endfunction

endpackage

// File: rtl/wl_addr_gen.sv
// Weight SRAM address generator: latches och_base = wbase + och*in_ch on
// load, then walks the input-channel index one step per read strobe.
module wl_addr_gen
   import acc_pkg::*;
#(
   parameter int unsigned AW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          step,
   input  logic [7:0]    och,
   input  logic [7:0]    in_ch,
   input  logic [AW-1:0] wbase,
   output logic [AW-1:0] addr,
   output logic [7:0]    ich,
   output logic          last
);

   logic [AW-1:0] och_base;
   logic [15:0]   prod;

   assign prod = mul8x8(och, in_ch);

   // Base address register and input-channel counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         och_base <= '0;
         ich      <= '0;
      end else if (load) begin
         och_base <= wbase + AW'(prod);
         ich      <= '0;
      end else if (step) begin
         ich <= ich + 8'd1;
      end
   end

   // Sum wraps modulo 2^AW by construction
   assign addr = och_base + AW'(ich);
   assign last = (ich == in_ch - 8'd1);

endmodule

// File: rtl/weight_loader.sv
// Weight loader: on each weight_start, copies the in_ch kernel words of one
// output channel from weight SRAM into the current fill bank of a ping-pong
// weight buffer, then pulses weight_done and publishes that bank.
module weight_loader
   import acc_pkg::*;
#(
   parameter int unsigned WW  = acc_pkg::WW,
   parameter int unsigned KW  = 9 * WW,
   parameter int unsigned AW  = 16,
   parameter int unsigned BAW = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [7:0]     in_ch,
   input  logic [7:0]     out_ch,
   input  logic [AW-1:0]  wbase_addr,
   input  logic           weight_start,
   input  logic [7:0]     weight_och_cnt,
   output logic           weight_done,
   output logic           wmem_rd_en,
   output logic [AW-1:0]  wmem_addr,
   input  logic [KW-1:0]  wmem_rd_data,
   output logic           wbuf_wr_en,
   output logic           wbuf_wr_bank,
   output logic [BAW-1:0] wbuf_wr_addr,
   output logic [KW-1:0]  wbuf_wr_data,
   output logic           wbuf_rd_bank,
   output logic           busy,
   output logic           err_pulse
);

   wl_state_t     state;
   logic [7:0]    och_q;
   logic [7:0]    in_ch_q;
   logic [AW-1:0] wbase_q;
   logic          fill_bank;

   logic          ag_load;
   logic          ag_last;
   logic [7:0]    ag_ich;
   logic [AW-1:0] ag_addr;

   assign ag_load = (state == WL_CALC);

   wl_addr_gen #(
      .AW (AW)
   ) u_addr_gen (
      .clk   (clk),
      .rst   (rst),
      .load  (ag_load),
      .step  (wmem_rd_en),
      .och   (och_q),
      .in_ch (in_ch_q),
      .wbase (wbase_q),
      .addr  (ag_addr),
      .ich   (ag_ich),
      .last  (ag_last)
   );

   assign wmem_addr    = ag_addr;
   assign wbuf_wr_data = wmem_rd_data;
   assign wbuf_wr_bank = fill_bank;

   // Control FSM with registered strobes, bank swap and error reporting.
   // The no-read path still passes through DRAIN so weight_done lands two
   // edges after the start, matching the read path's CALC+DRAIN overhead.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= WL_IDLE;
         och_q        <= '0;
         in_ch_q      <= '0;
         wbase_q      <= '0;
         fill_bank    <= 1'b0;
         wbuf_rd_bank <= 1'b0;
         wmem_rd_en   <= 1'b0;
         weight_done  <= 1'b0;
         err_pulse    <= 1'b0;
         busy         <= 1'b0;
      end else begin
         weight_done <= 1'b0;
         err_pulse   <= 1'b0;
         case (state)
            WL_IDLE: begin
               if (weight_start) begin
                  och_q   <= weight_och_cnt;
                  in_ch_q <= in_ch;
                  wbase_q <= wbase_addr;
                  busy    <= 1'b1;
                  state   <= WL_CALC;
               end
            end
            WL_CALC: begin
               err_pulse <= weight_start || (och_q >= out_ch);
               if ((in_ch_q == '0) || (och_q >= out_ch)) begin
                  state <= WL_DRAIN;
               end else begin
                  wmem_rd_en <= 1'b1;
                  state      <= WL_READ;
               end
            end
            WL_READ: begin
               err_pulse <= weight_start;
               if (ag_last) begin
                  wmem_rd_en <= 1'b0;
                  state      <= WL_DRAIN;
               end
            end
            WL_DRAIN: begin
               err_pulse   <= weight_start;
               weight_done <= 1'b1;
               state       <= WL_DONE;
            end
            WL_DONE: begin
               err_pulse    <= weight_start;
               wbuf_rd_bank <= fill_bank;
               fill_bank    <= ~fill_bank;
               busy         <= 1'b0;
               state        <= WL_IDLE;
            end
            default: begin
               wmem_rd_en <= 1'b0;
               busy       <= 1'b0;
               state      <= WL_IDLE;
            end
         endcase
      end
   end

   // Buffer write strobe/address trail the SRAM read by one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wbuf_wr_en   <= 1'b0;
         wbuf_wr_addr <= '0;
      end else begin
         wbuf_wr_en <= wmem_rd_en;
         if (wmem_rd_en) begin
            wbuf_wr_addr <= BAW'(ag_ich);
         end
      end
   end

endmodule

// File: tb/tb_weight_loader.sv
// Directed testbench for weight_loader: single load, back-to-back loads,
// no-read paths, start while busy, mid-transfer reset and address wrap.
module tb_weight_loader;
   import acc_pkg::*;

   localparam int unsigned AW  = 16;
   localparam int unsigned BAW = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [7:0]     in_ch = 8'd0;
   logic [7:0]     out_ch = 8'd0;
   logic [AW-1:0]  wbase_addr = '0;
   logic           weight_start = 1'b0;
   logic [7:0]     weight_och_cnt = 8'd0;
   logic           weight_done;
   logic           wmem_rd_en;
   logic [AW-1:0]  wmem_addr;
   logic [KW-1:0]  wmem_rd_data = '0;
   logic           wbuf_wr_en;
   logic           wbuf_wr_bank;
   logic [BAW-1:0] wbuf_wr_addr;
   logic [KW-1:0]  wbuf_wr_data;
   logic           wbuf_rd_bank;
   logic           busy;
   logic           err_pulse;

   int unsigned tests = 0;
   int unsigned failed = 0;

   weight_loader #(
      .WW  (8),
      .AW  (AW),
      .BAW (BAW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .in_ch          (in_ch),
      .out_ch         (out_ch),
      .wbase_addr     (wbase_addr),
      .weight_start   (weight_start),
      .weight_och_cnt (weight_och_cnt),
      .weight_done    (weight_done),
      .wmem_rd_en     (wmem_rd_en),
      .wmem_addr      (wmem_addr),
      .wmem_rd_data   (wmem_rd_data),
      .wbuf_wr_en     (wbuf_wr_en),
      .wbuf_wr_bank   (wbuf_wr_bank),
      .wbuf_wr_addr   (wbuf_wr_addr),
      .wbuf_wr_data   (wbuf_wr_data),
      .wbuf_rd_bank   (wbuf_rd_bank),
      .busy           (busy),
      .err_pulse      (err_pulse)
   );

   always #5 clk = ~clk;

   // SRAM model: returns its own address as data one cycle after the strobe
   always @(posedge clk) begin
      if (wmem_rd_en) wmem_rd_data <= {56'd0, wmem_addr};
   end

   task automatic do_reset();
      weight_start = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Drive a one-cycle start; returns at the negedge after the sampling edge
   task automatic pulse_start(input logic [7:0] och);
      weight_och_cnt = och;
      weight_start = 1'b1;
      @(negedge clk);
      weight_start = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (weight_done !== 1'b0) begin failed++; $display("FAIL reset_done: got %b want 0", weight_done); end
      tests++; if (wmem_rd_en !== 1'b0) begin failed++; $display("FAIL reset_rd_en: got %b want 0", wmem_rd_en); end
      tests++; if (wbuf_wr_en !== 1'b0) begin failed++; $display("FAIL reset_wr_en: got %b want 0", wbuf_wr_en); end
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests++; if (err_pulse !== 1'b0) begin failed++; $display("FAIL reset_err: got %b want 0", err_pulse); end
      tests++; if (wbuf_wr_bank !== 1'b0) begin failed++; $display("FAIL reset_wr_bank: got %b want 0", wbuf_wr_bank); end
      tests++; if (wbuf_rd_bank !== 1'b0) begin failed++; $display("FAIL reset_rd_bank: got %b want 0", wbuf_rd_bank); end
      tests++; if (wmem_addr !== 16'h0000) begin failed++; $display("FAIL reset_addr: got %h want 0000", wmem_addr); end
   endtask

   // in_ch=4, out_ch=8, base=0x100, och=2 -> reads 0x108..0x10B, done at edge 6
   task automatic test_single();
      int unsigned n_rd = 0;
      int unsigned n_wr = 0;
      do_reset();
      in_ch = 8'd4; out_ch = 8'd8; wbase_addr = 16'h0100;
      pulse_start(8'd2);
      for (int unsigned c = 1; c <= 10; c++) begin
         @(negedge clk);
         tests++; if (wmem_rd_en !== (c >= 1 && c <= 4)) begin failed++; $display("FAIL single_rd_en c=%0d: got %b", c, wmem_rd_en); end
         tests++; if (wbuf_wr_en !== (c >= 2 && c <= 5)) begin failed++; $display("FAIL single_wr_en c=%0d: got %b", c, wbuf_wr_en); end
         tests++; if (weight_done !== (c == 6)) begin failed++; $display("FAIL single_done c=%0d: got %b", c, weight_done); end
         tests++; if (busy !== (c <= 6)) begin failed++; $display("FAIL single_busy c=%0d: got %b", c, busy); end
         tests++; if (err_pulse !== 1'b0) begin failed++; $display("FAIL single_err c=%0d: got %b want 0", c, err_pulse); end
         if (wmem_rd_en) begin
            tests++; if (wmem_addr !== 16'(32'h108 + n_rd)) begin failed++; $display("FAIL single_rd_addr: got %h want %h", wmem_addr, 16'(32'h108 + n_rd)); end
            n_rd++;
         end
         if (wbuf_wr_en) begin
            tests++; if (wbuf_wr_addr !== 8'(n_wr)) begin failed++; $display("FAIL single_wr_addr: got %0d want %0d", wbuf_wr_addr, n_wr); end
            tests++; if (wbuf_wr_data !== {56'd0, 16'(32'h108 + n_wr)}) begin failed++; $display("FAIL single_wr_data: got %h want %h", wbuf_wr_data[15:0], 16'(32'h108 + n_wr)); end
            tests++; if (wbuf_wr_bank !== 1'b0) begin failed++; $display("FAIL single_wr_bank: got %b want 0", wbuf_wr_bank); end
            n_wr++;
         end
      end
      tests++; if (n_rd != 4) begin failed++; $display("FAIL single_n_rd: got %0d want 4", n_rd); end
      tests++; if (n_wr != 4) begin failed++; $display("FAIL single_n_wr: got %0d want 4", n_wr); end
      tests++; if (wbuf_rd_bank !== 1'b0) begin failed++; $display("FAIL single_rd_bank: got %b want 0", wbuf_rd_bank); end
      tests++; if (wbuf_wr_bank !== 1'b1) begin failed++; $display("FAIL single_fill_bank: got %b want 1", wbuf_wr_bank); end
   endtask

   // och=0 then och=1 right after done: contiguous addresses, banks 0 then 1
   task automatic test_back_to_back();
      int unsigned n_rd = 0;
      int unsigned n_wr = 0;
      int unsigned n_done = 0;
      int unsigned done2_cyc = 0;
      bit pend = 1'b0;
      do_reset();
      in_ch = 8'd4; out_ch = 8'd8; wbase_addr = 16'h0100;
      pulse_start(8'd0);
      for (int unsigned c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (weight_start) weight_start = 1'b0;
         if (wmem_rd_en) begin
            tests++; if (wmem_addr !== 16'(32'h100 + n_rd)) begin failed++; $display("FAIL b2b_rd_addr: got %h want %h", wmem_addr, 16'(32'h100 + n_rd)); end
            n_rd++;
         end
         if (wbuf_wr_en) begin
            tests++; if (wbuf_wr_bank !== (n_wr >= 4)) begin failed++; $display("FAIL b2b_wr_bank n=%0d: got %b", n_wr, wbuf_wr_bank); end
            tests++; if (wbuf_wr_addr !== 8'(n_wr % 4)) begin failed++; $display("FAIL b2b_wr_addr: got %0d want %0d", wbuf_wr_addr, n_wr % 4); end
            n_wr++;
         end
         if (pend) begin
            pend = 1'b0;
            tests++; if (wbuf_rd_bank !== 1'b0) begin failed++; $display("FAIL b2b_rd_bank1: got %b want 0", wbuf_rd_bank); end
            weight_och_cnt = 8'd1;
            weight_start = 1'b1;
         end
         if (weight_done) begin
            n_done++;
            if (n_done == 1) pend = 1'b1;
            if (n_done == 2) done2_cyc = c;
         end
      end
      tests++; if (n_rd != 8) begin failed++; $display("FAIL b2b_n_rd: got %0d want 8", n_rd); end
      tests++; if (n_done != 2) begin failed++; $display("FAIL b2b_n_done: got %0d want 2", n_done); end
      tests++; if (done2_cyc != 14) begin failed++; $display("FAIL b2b_done2_cyc: got %0d want 14", done2_cyc); end
      tests++; if (wbuf_rd_bank !== 1'b1) begin failed++; $display("FAIL b2b_rd_bank2: got %b want 1", wbuf_rd_bank); end
      tests++; if (wbuf_wr_bank !== 1'b0) begin failed++; $display("FAIL b2b_fill_bank: got %b want 0", wbuf_wr_bank); end
   endtask

   // No-read paths: in_ch==0, or och>=out_ch (which also flags an error)
   task automatic test_no_read(input logic [7:0] ich_n, input logic [7:0] och, input bit exp_err);
      int unsigned n_rw = 0;
      do_reset();
      in_ch = ich_n; out_ch = 8'd8; wbase_addr = 16'h0100;
      pulse_start(och);
      for (int unsigned c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (wmem_rd_en || wbuf_wr_en) n_rw++;
         tests++; if (weight_done !== (c == 2)) begin failed++; $display("FAIL noread_done in_ch=%0d och=%0d c=%0d: got %b", ich_n, och, c, weight_done); end
         tests++; if (err_pulse !== (exp_err && c == 1)) begin failed++; $display("FAIL noread_err in_ch=%0d och=%0d c=%0d: got %b", ich_n, och, c, err_pulse); end
      end
      tests++; if (n_rw != 0) begin failed++; $display("FAIL noread_strobes in_ch=%0d och=%0d: got %0d want 0", ich_n, och, n_rw); end
      tests++; if (wbuf_wr_bank !== 1'b1) begin failed++; $display("FAIL noread_fill_bank: got %b want 1", wbuf_wr_bank); end
   endtask

   // Starts during READ and during DONE are ignored and flagged
   task automatic test_start_busy();
      int unsigned n_rd = 0;
      int unsigned n_done = 0;
      do_reset();
      in_ch = 8'd4; out_ch = 8'd8; wbase_addr = 16'h0100;
      pulse_start(8'd2);
      for (int unsigned c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (wmem_rd_en) begin
            tests++; if (wmem_addr !== 16'(32'h108 + n_rd)) begin failed++; $display("FAIL busy_rd_addr: got %h want %h", wmem_addr, 16'(32'h108 + n_rd)); end
            n_rd++;
         end
         if (weight_done) n_done++;
         tests++; if (err_pulse !== (c == 3 || c == 7)) begin failed++; $display("FAIL busy_err c=%0d: got %b", c, err_pulse); end
         tests++; if (busy !== (c <= 6)) begin failed++; $display("FAIL busy_busy c=%0d: got %b", c, busy); end
         weight_start = (c == 2 || c == 6);
         weight_och_cnt = 8'd5;
      end
      tests++; if (n_rd != 4) begin failed++; $display("FAIL busy_n_rd: got %0d want 4", n_rd); end
      tests++; if (n_done != 1) begin failed++; $display("FAIL busy_n_done: got %0d want 1", n_done); end
   endtask

   // Reset during READ (ich=2) aborts; a fresh start then fills bank 0
   task automatic test_reset_mid();
      int unsigned n_rd = 0;
      int unsigned n_done = 0;
      do_reset();
      in_ch = 8'd4; out_ch = 8'd8; wbase_addr = 16'h0100;
      pulse_start(8'd0);
      repeat (10) @(negedge clk);
      pulse_start(8'd2);
      repeat (3) @(negedge clk);
      tests++; if (wmem_addr !== 16'h010A) begin failed++; $display("FAIL rstmid_pre_addr: got %h want 010a", wmem_addr); end
      rst = 1'b1;
      #1;
      tests++; if (wmem_rd_en !== 1'b0) begin failed++; $display("FAIL rstmid_rd_en: got %b want 0", wmem_rd_en); end
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      tests++; if (wbuf_wr_en !== 1'b0) begin failed++; $display("FAIL rstmid_wr_en: got %b want 0", wbuf_wr_en); end
      tests++; if (wbuf_wr_bank !== 1'b0) begin failed++; $display("FAIL rstmid_wr_bank: got %b want 0", wbuf_wr_bank); end
      tests++; if (wmem_addr !== 16'h0000) begin failed++; $display("FAIL rstmid_addr: got %h want 0000", wmem_addr); end
      @(negedge clk);
      rst = 1'b0;
      for (int unsigned c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (weight_done) n_done++;
      end
      tests++; if (n_done != 0) begin failed++; $display("FAIL rstmid_no_done: got %0d want 0", n_done); end
      pulse_start(8'd1);
      for (int unsigned c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (wmem_rd_en) begin
            tests++; if (wmem_addr !== 16'(32'h104 + n_rd)) begin failed++; $display("FAIL rstmid_rd_addr: got %h want %h", wmem_addr, 16'(32'h104 + n_rd)); end
            n_rd++;
         end
         if (wbuf_wr_en) begin
            tests++; if (wbuf_wr_bank !== 1'b0) begin failed++; $display("FAIL rstmid_new_bank: got %b want 0", wbuf_wr_bank); end
         end
         tests++; if (weight_done !== (c == 6)) begin failed++; $display("FAIL rstmid_done c=%0d: got %b", c, weight_done); end
      end
      tests++; if (n_rd != 4) begin failed++; $display("FAIL rstmid_n_rd: got %0d want 4", n_rd); end
   endtask

   // base=0xFFFC, och=1, in_ch=3 -> reads 0xFFFF, 0x0000, 0x0001
   task automatic test_addr_wrap();
      int unsigned n_rd = 0;
      do_reset();
      in_ch = 8'd3; out_ch = 8'd8; wbase_addr = 16'hFFFC;
      pulse_start(8'd1);
      for (int unsigned c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (wmem_rd_en) begin
            tests++; if (wmem_addr !== 16'(32'hFFFF + n_rd)) begin failed++; $display("FAIL wrap_rd_addr: got %h want %h", wmem_addr, 16'(32'hFFFF + n_rd)); end
            n_rd++;
         end
         tests++; if (weight_done !== (c == 5)) begin failed++; $display("FAIL wrap_done c=%0d: got %b", c, weight_done); end
         tests++; if (err_pulse !== 1'b0) begin failed++; $display("FAIL wrap_err c=%0d: got %b want 0", c, err_pulse); end
      end
      tests++; if (n_rd != 3) begin failed++; $display("FAIL wrap_n_rd: got %0d want 3", n_rd); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_no_read(8'd0, 8'd0, 1'b0);
      test_no_read(8'd4, 8'd8, 1'b1);
      test_start_busy();
      test_reset_mid();
      test_addr_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
